// File: rtl/hsm_frame_engine.sv
// hsm_frame_engine
// Byte-level framing engine between the parallel Raspberry Pi interface and
// the HSM core. Hunts for the 0xA5 sync byte, assembles a
// {header, payload, checksum} request frame, hands the validated command to
// the core and returns the core's status as a two-byte reply (0x5A, status)
// followed by a send pulse.
//
// Ports:
//   clk, rst            system clock, asynchronous active-low reset
//   rx_full, rx_data    receive byte available / received byte
//   rx_read             one-cycle pop pulse to the interface
//   tx_full             transmit holding register occupied
//   tx_data, tx_write   byte to transmit / one-cycle push pulse
//   tx_send             one-cycle end-of-reply pulse
//   cmd_*               command to the core (valid/ready)
//   rsp_*               status from the core (valid/ready)
//   err_count           saturating count of frame errors
//   state_dbg           current FSM state (debug)
//
// Handshakes: a transfer on cmd_* or rsp_* happens at the rising clock edge
// where valid and ready are both high; once raised, valid and its payload are
// held stable until that edge. The interface side uses pulses instead: a pop
// or push is a one-cycle rx_read / tx_write, and the full flag is ignored in
// the cycle after a pulse while the interface updates it.
module hsm_frame_engine #(
    parameter int BURST_SIZE     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rx_full,
    input  logic [DATA_WIDTH-1:0]            rx_data,
    output logic                             rx_read,
    input  logic                             tx_full,
    output logic [DATA_WIDTH-1:0]            tx_data,
    output logic                             tx_write,
    output logic                             tx_send,
    output logic                             cmd_valid,
    input  logic                             cmd_ready,
    output logic [3:0]                       cmd_opcode,
    output logic [3:0]                       cmd_len,
    output logic [BURST_SIZE*DATA_WIDTH-1:0] cmd_data,
    input  logic                             rsp_valid,
    output logic                             rsp_ready,
    input  logic [7:0]                       rsp_status,
    output logic [7:0]                       err_count,
    output logic [3:0]                       state_dbg
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        HDR      = 4'd1,
        PAYLOAD  = 4'd2,
        CSUM     = 4'd3,
        DISPATCH = 4'd4,
        WAIT_RSP = 4'd5,
        TX_SYNC  = 4'd6,
        TX_STAT  = 4'd7,
        TX_SEND  = 4'd8
    } state_t;

    localparam logic [3:0]    MAX_LEN = 4'(BURST_SIZE);
    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t                  state;
    logic [DATA_WIDTH-1:0]   xor_acc;
    logic [3:0]              idx;
    logic [7:0]              status;
    logic [TW-1:0]           to_cnt;

    logic rx_take;
    logic tx_ok;
    logic in_rx;
    logic timed_out;

    // A pop/push pulse high this cycle means the flag is stale; wait a cycle.
    assign rx_take   = rx_full && !rx_read;
    assign tx_ok     = !tx_full && !tx_write && !tx_send;
    assign in_rx     = (state == HDR) || (state == PAYLOAD) || (state == CSUM);
    assign timed_out = in_rx && !rx_take && (to_cnt == TO_LAST);
    assign state_dbg = state;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Inter-byte watchdog: only runs while a frame is being received.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (!in_rx || rx_take || timed_out) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            rx_read    <= 1'b0;
            tx_write   <= 1'b0;
            tx_send    <= 1'b0;
            cmd_valid  <= 1'b0;
            rsp_ready  <= 1'b0;
            tx_data    <= '0;
            cmd_opcode <= '0;
            cmd_len    <= '0;
            cmd_data   <= '0;
            err_count  <= '0;
            xor_acc    <= '0;
            idx        <= '0;
            status     <= '0;
        end else begin
            rx_read  <= 1'b0;
            tx_write <= 1'b0;
            tx_send  <= 1'b0;
            if (timed_out) begin
                // Abandoned frame: no reply, just count it.
                err_count <= sat_inc(err_count);
                state     <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (rx_take) begin
                            rx_read <= 1'b1;
                            if (rx_data == 8'hA5) state <= HDR;
                        end
                    end
                    HDR: begin
                        if (rx_take) begin
                            rx_read    <= 1'b1;
                            cmd_opcode <= rx_data[7:4];
                            cmd_len    <= rx_data[3:0];
                            xor_acc    <= rx_data;
                            cmd_data   <= '0;
                            idx        <= '0;
                            if (rx_data[3:0] > MAX_LEN) begin
                                status    <= 8'hE2;
                                err_count <= sat_inc(err_count);
                                state     <= TX_SYNC;
                            end else if (rx_data[3:0] == 4'd0) begin
                                state <= CSUM;
                            end else begin
                                state <= PAYLOAD;
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (rx_take) begin
                            rx_read <= 1'b1;
                            cmd_data[DATA_WIDTH*int'(idx) +: DATA_WIDTH] <= rx_data;
                            xor_acc <= xor_acc ^ rx_data;
                            idx     <= idx + 4'd1;
                            if (idx == cmd_len - 4'd1) state <= CSUM;
                        end
                    end
                    CSUM: begin
                        if (rx_take) begin
                            rx_read <= 1'b1;
                            if (rx_data == xor_acc) begin
                                cmd_valid <= 1'b1;
                                state     <= DISPATCH;
                            end else begin
                                status    <= 8'hE1;
                                err_count <= sat_inc(err_count);
                                state     <= TX_SYNC;
                            end
                        end
                    end
                    DISPATCH: begin
                        // rsp_ready rises on the same edge cmd_valid falls.
                        if (cmd_ready) begin
                            cmd_valid <= 1'b0;
                            rsp_ready <= 1'b1;
                            state     <= WAIT_RSP;
                        end
                    end
                    WAIT_RSP: begin
                        if (rsp_valid) begin
                            rsp_ready <= 1'b0;
                            status    <= rsp_status;
                            state     <= TX_SYNC;
                        end
                    end
                    TX_SYNC: begin
                        if (tx_ok) begin
                            tx_data  <= 8'h5A;
                            tx_write <= 1'b1;
                            state    <= TX_STAT;
                        end
                    end
                    TX_STAT: begin
                        if (tx_ok) begin
                            tx_data  <= status;
                            tx_write <= 1'b1;
                            state    <= TX_SEND;
                        end
                    end
                    TX_SEND: begin
                        if (tx_ok) begin
                            tx_send <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hsm_frame_engine.sv
// Bench for hsm_frame_engine: table of request frames with expected command
// and reply, plus hand-written timeout, reset and backpressure sequences.
module tb_hsm_frame_engine;
    localparam int BS = 8;
    localparam int TO = 40;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx_full, rx_read, tx_full, tx_write, tx_send;
    logic [7:0]    rx_data, tx_data;
    logic          cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [3:0]    cmd_opcode, cmd_len, state_dbg;
    logic [BS*8-1:0] cmd_data;
    logic [7:0]    rsp_status, err_count;

    always #5 clk = ~clk;

    hsm_frame_engine #(.BURST_SIZE(BS), .DATA_WIDTH(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .rx_full(rx_full), .rx_data(rx_data), .rx_read(rx_read),
        .tx_full(tx_full), .tx_data(tx_data), .tx_write(tx_write), .tx_send(tx_send),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .err_count(err_count), .state_dbg(state_dbg)
    );

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  len;
        logic [63:0] data;
        logic [7:0]  rsp;
    } cmd_t;

    typedef struct {
        int               n;
        logic [15:0][7:0] bytes;
        logic             has_cmd;
        cmd_t             cmd;
        logic [7:0]       stat;
        logic             err_inc;
    } vec_t;

    int         checks = 0;
    int         failures = 0;
    logic [8:0] exp_q[$];      // {is_send, byte}
    cmd_t       cmd_q[$];
    logic [7:0] rx_q[$];
    int         pops = 0;
    int         writes = 0;
    int         pulse_err = 0;
    int         overlap_err = 0;
    logic       core_auto = 1'b1;
    logic       rsp_hs = 1'b0;
    int         exp_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Receive side of the interface: byte queue, cleared flag after a pop.
    initial begin
        rx_full = 1'b0;
        rx_data = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (rx_read) begin
                if (rx_q.size() > 0) void'(rx_q.pop_front());
                pops++;
                rx_full = 1'b0;
            end else begin
                rx_full = (rx_q.size() > 0);
                rx_data = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
            end
        end
    end

    // Transmit monitor + pulse/overlap watch.
    initial begin
        logic p_w, p_s, p_r;
        logic [8:0] e;
        p_w = 0; p_s = 0; p_r = 0;
        forever begin
            @(negedge clk);
            if (tx_write) writes++;
            if (tx_write || tx_send) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_unexpected actual=%0h required=none", {tx_send, tx_data});
                end else begin
                    e = exp_q.pop_front();
                    check("tx_order", {55'd0, tx_send, (tx_write ? tx_data : 8'h00)}, {55'd0, e});
                end
            end
            if ((p_w && tx_write) || (p_s && tx_send) || (p_r && rx_read)) pulse_err++;
            if (cmd_valid && rsp_ready) overlap_err++;
            p_w = tx_write; p_s = tx_send; p_r = rx_read;
        end
    end

    // Core model: random cmd_ready, returns the queued status after a command.
    initial begin
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_status = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (rsp_hs) begin
                rsp_valid = 1'b0;
                rsp_hs    = 1'b0;
            end
            if (core_auto) cmd_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        cmd_t c;
        forever begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) rsp_hs = 1'b1;
            if (cmd_valid && cmd_ready) begin
                if (cmd_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL cmd_unexpected actual=%0h required=none", cmd_opcode);
                    rsp_status = 8'h00;
                end else begin
                    c = cmd_q.pop_front();
                    check("cmd_opcode", {60'd0, cmd_opcode}, {60'd0, c.op});
                    check("cmd_len", {60'd0, cmd_len}, {60'd0, c.len});
                    check("cmd_data", cmd_data, c.data);
                    rsp_status = c.rsp;
                end
                rsp_valid = 1'b1;
            end
        end
    end

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while (k < budget && !(rx_q.size() == 0 && exp_q.size() == 0 && cmd_q.size() == 0
                               && state_dbg == 4'd0 && !rx_read)) begin
            @(negedge clk);
            k++;
        end
        check({name, "_drain"}, {63'd0, (k < budget)}, 64'd1);
    endtask

    task automatic wait_pops(input int target, input int budget);
        int k = 0;
        while (k < budget && pops < target) begin
            @(negedge clk);
            k++;
        end
        check("pop_wait", {63'd0, (pops >= target)}, 64'd1);
    endtask

    task automatic push_reply(input logic [7:0] stat);
        exp_q.push_back({1'b0, 8'h5A});
        exp_q.push_back({1'b0, stat});
        exp_q.push_back(9'h100);
    endtask

    vec_t vecs[7];

    initial begin
        int p0, w0;
        logic [7:0] x, b;
        // ---- vector table ----
        foreach (vecs[i]) begin
            vecs[i].bytes = '0;
            vecs[i].cmd   = '{op: 4'd0, len: 4'd0, data: 64'd0, rsp: 8'd0};
        end
        vecs[0].n = 6; vecs[0].bytes[5:0] = {8'h33, 8'h33, 8'h22, 8'h11, 8'h33, 8'hA5};
        vecs[0].has_cmd = 1; vecs[0].cmd = '{op: 4'd3, len: 4'd3, data: 64'h332211, rsp: 8'h00};
        vecs[0].stat = 8'h00; vecs[0].err_inc = 0;
        vecs[1].n = 5; vecs[1].bytes[4:0] = {8'h40, 8'h40, 8'hA5, 8'hFF, 8'h00};
        vecs[1].has_cmd = 1; vecs[1].cmd = '{op: 4'd4, len: 4'd0, data: 64'd0, rsp: 8'h3C};
        vecs[1].stat = 8'h3C; vecs[1].err_inc = 0;
        vecs[2].n = 6; vecs[2].bytes[5:0] = {8'h00, 8'h33, 8'h22, 8'h11, 8'h33, 8'hA5};
        vecs[2].has_cmd = 0; vecs[2].stat = 8'hE1; vecs[2].err_inc = 1;
        vecs[3].n = 2; vecs[3].bytes[1:0] = {8'h19, 8'hA5};
        vecs[3].has_cmd = 0; vecs[3].stat = 8'hE2; vecs[3].err_inc = 1;
        vecs[4].n = 11;
        vecs[4].bytes[10:0] = {8'h70, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h78, 8'hA5};
        vecs[4].has_cmd = 1; vecs[4].cmd = '{op: 4'd7, len: 4'd8, data: 64'h0807060504030201, rsp: 8'h81};
        vecs[4].stat = 8'h81; vecs[4].err_inc = 0;
        vecs[5].n = 2; vecs[5].bytes[1:0] = {8'h2F, 8'hA5};
        vecs[5].has_cmd = 0; vecs[5].stat = 8'hE2; vecs[5].err_inc = 1;
        // random legal frame, checksum from the bench's own XOR
        vecs[6].cmd.op  = 4'($urandom_range(0, 15));
        vecs[6].cmd.len = 4'($urandom_range(1, BS));
        vecs[6].cmd.rsp = 8'($urandom_range(0, 255));
        vecs[6].bytes[0] = 8'hA5;
        vecs[6].bytes[1] = {vecs[6].cmd.op, vecs[6].cmd.len};
        x = {vecs[6].cmd.op, vecs[6].cmd.len};
        for (int k = 0; k < int'(vecs[6].cmd.len); k++) begin
            b = 8'($urandom_range(0, 255));
            vecs[6].bytes[2 + k] = b;
            vecs[6].cmd.data[8*k +: 8] = b;
            x = x ^ b;
        end
        vecs[6].bytes[2 + int'(vecs[6].cmd.len)] = x;
        vecs[6].n = 3 + int'(vecs[6].cmd.len);
        vecs[6].has_cmd = 1; vecs[6].stat = vecs[6].cmd.rsp; vecs[6].err_inc = 0;

        // ---- reset ----
        tx_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", {60'd0, state_dbg}, 64'd0);
        check("rst_pulses", {59'd0, rx_read, tx_write, tx_send, cmd_valid, rsp_ready}, 64'd0);
        check("rst_fields", {44'd0, tx_data, cmd_opcode, cmd_len, err_count}, 64'd0);
        check("rst_cmd_data", cmd_data, 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // ---- table-driven frames ----
        for (int i = 0; i < 7; i++) begin
            p0 = pops;
            for (int k = 0; k < vecs[i].n; k++) rx_q.push_back(vecs[i].bytes[k]);
            if (vecs[i].has_cmd) cmd_q.push_back(vecs[i].cmd);
            push_reply(vecs[i].stat);
            if (vecs[i].err_inc) exp_err++;
            wait_drain($sformatf("vec%0d", i), 600);
            check($sformatf("vec%0d_pops", i), 64'(pops - p0), 64'(vecs[i].n));
            check($sformatf("vec%0d_err", i), {56'd0, err_count}, 64'(exp_err));
        end

        // ---- timeout mid-payload: no reply, error counted ----
        p0 = pops; w0 = writes;
        rx_q.push_back(8'hA5); rx_q.push_back(8'h33); rx_q.push_back(8'h11);
        wait_pops(p0 + 3, 100);
        repeat (TO + 10) @(negedge clk);
        exp_err++;
        check("to_state", {60'd0, state_dbg}, 64'd0);
        check("to_err", {56'd0, err_count}, 64'(exp_err));
        check("to_no_tx", 64'(writes), 64'(w0));

        // ---- asynchronous reset mid-payload ----
        p0 = pops; w0 = writes;
        rx_q.push_back(8'hA5); rx_q.push_back(8'h33); rx_q.push_back(8'h11); rx_q.push_back(8'h22);
        wait_pops(p0 + 3, 100);
        #2 rst = 1'b0;
        #1;
        rx_q.delete();
        check("arst_state", {60'd0, state_dbg}, 64'd0);
        check("arst_pulses", {59'd0, rx_read, tx_write, tx_send, cmd_valid, rsp_ready}, 64'd0);
        check("arst_fields", {44'd0, tx_data, cmd_opcode, cmd_len, err_count}, 64'd0);
        check("arst_cmd_data", cmd_data, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        exp_err = 0;
        repeat (20) @(negedge clk);
        check("arst_idle", {60'd0, state_dbg}, 64'd0);
        check("arst_no_tx", 64'(writes), 64'(w0));

        // ---- backpressure on both the command and transmit paths ----
        @(posedge clk);
        #1;
        core_auto = 1'b0;
        cmd_ready = 1'b0;
        tx_full   = 1'b1;
        w0 = writes;
        rx_q.push_back(8'hA5); rx_q.push_back(8'h12); rx_q.push_back(8'hAB);
        rx_q.push_back(8'hCD); rx_q.push_back(8'h74);
        cmd_q.push_back('{op: 4'd1, len: 4'd2, data: 64'hCDAB, rsp: 8'h42});
        push_reply(8'h42);
        begin
            int k = 0;
            while (k < 200 && !cmd_valid) begin
                @(negedge clk);
                k++;
            end
        end
        for (int c = 0; c < 20; c++) begin
            check("bp_valid", {63'd0, cmd_valid}, 64'd1);
            check("bp_fields", {56'd0, cmd_opcode, cmd_len}, 64'h12);
            check("bp_data", cmd_data, 64'hCDAB);
            @(negedge clk);
        end
        @(posedge clk);
        #1 cmd_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("bp_tx_state", {60'd0, state_dbg}, 64'd6);
        check("bp_no_tx", 64'(writes), 64'(w0));
        @(posedge clk);
        #1 tx_full = 1'b0;
        wait_drain("bp", 300);
        check("bp_err", {56'd0, err_count}, 64'(exp_err));

        check("pulse_width", 64'(pulse_err), 64'd0);
        check("cmd_rsp_overlap", 64'(overlap_err), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
